// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and width definitions shared by the sequential ALU
// Contents: OP_W (opcode width), alu_op_t (opcode encoding), flags_t (zero/carry/neg/ovf).
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_MUL = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue/result handshake bundle between control unit, ALU and writeback
// Issue side: in_valid, in_ready, op, a, b.
// Result side: out_valid, out_ready, result, result_hi, flag_zero/carry/neg/ovf, busy.
// master = control unit / writeback side, slave = ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_neg;
  logic             flag_ovf;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
           flag_zero, flag_carry, flag_neg, flag_ovf, busy
  );

endinterface

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one partial product per cycle
// Ports: clk, rst (async, active-high), start (load operands), a/b (operands),
//        busy (iterating), done (final step this cycle), product_hi/product_lo (valid with done).
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  // The multiplier register doubles as the low half of the product: each step
  // shifts the sum's low bit into its top while the consumed LSB falls out.
  always_comb begin
    addend = mplier[0] ? {1'b0, mcand} : '0;
    sum    = {1'b0, acc} + addend;
  end

  // Product is presented combinationally during the last step so the caller
  // can register it on the same edge the final iteration completes.
  assign done       = busy && (cnt == CNT_LAST);
  assign product_hi = sum[WIDTH:1];
  assign product_lo = {sum[0], mplier[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= CNT_INIT;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= sum[WIDTH:1];
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt - 1'b1;
      if (cnt == CNT_LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result/flags and optional iterative MUL
// Ports: clk, rst (async, active-high), bus (alu_seq_if.slave: issue handshake,
//        result handshake, result/result_hi, four flags, busy).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]       state;
  alu_op_t          op_e;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  flags_t           mul_flags;

  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sc_res;
  flags_t           sc_flags;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  flags_t           flags_q;

  assign op_e      = alu_op_t'(bus.op);
  assign is_mul    = (MUL_EN != 0) && (op_e == OP_MUL);
  assign bus.in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign mul_start = accept && is_mul;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start      (mul_start),
        .a          (bus.a),
        .b          (bus.b),
        .busy       (mul_busy),
        .done       (mul_done),
        .product_hi (mul_hi),
        .product_lo (mul_lo)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_hi   = '0;
      assign mul_lo   = '0;
    end
  endgenerate

  always_comb begin
    mul_flags.zero  = ({mul_hi, mul_lo} == '0);
    mul_flags.carry = (mul_hi != '0);
    mul_flags.neg   = mul_lo[WIDTH-1];
    mul_flags.ovf   = 1'b0;
  end

  // Single-cycle datapath. INC/DEC reuse the add/sub path with a constant 1,
  // so their carry/borrow and overflow come out of the same equations.
  always_comb begin
    opnd = (op_e == OP_INC || op_e == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.b;
    sum  = {1'b0, bus.a} + {1'b0, opnd};
    diff = {1'b0, bus.a} - {1'b0, opnd};
    sc_res         = '0;
    sc_flags.carry = 1'b0;
    sc_flags.ovf   = 1'b0;
    case (op_e)
      OP_ADD, OP_INC: begin
        sc_res         = sum[WIDTH-1:0];
        sc_flags.carry = sum[WIDTH];
        sc_flags.ovf   = (bus.a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        sc_res         = diff[WIDTH-1:0];
        sc_flags.carry = diff[WIDTH];
        sc_flags.ovf   = (bus.a[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT: sc_res = ~bus.a;
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_XOR: sc_res = bus.a ^ bus.b;
      OP_SHL: begin
        sc_res         = bus.a << 1;
        sc_flags.carry = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        sc_res         = bus.a >> 1;
        sc_flags.carry = bus.a[0];
      end
      // Undefined opcodes (and MUL when not built) leave sc_res at zero,
      // which yields zero=1 and all other flags clear.
      default: ;
    endcase
    sc_flags.zero = (sc_res == '0);
    sc_flags.neg  = sc_res[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        state <= ST_MUL;
      end
    end else if (mul_done) begin
      state <= ST_IDLE;
    end
  end

  // Output register. A MUL completion and a single-cycle load are mutually
  // exclusive (one needs ST_MUL, the other ST_IDLE); either may coincide with
  // the previous result draining, since accept already required a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_lo;
      result_hi_q <= mul_hi;
      flags_q     <= mul_flags;
    end else if (accept && !is_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= sc_res;
      result_hi_q <= '0;
      flags_q     <= sc_flags;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.result_hi  = result_hi_q;
  assign bus.flag_zero  = flags_q.zero;
  assign bus.flag_carry = flags_q.carry;
  assign bus.flag_neg   = flags_q.neg;
  assign bus.flag_ovf   = flags_q.ovf;
  assign bus.busy       = mul_busy;

endmodule
